// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM arbiter: FSM state encoding and port indices.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPU (port 0) and loader (port 1).
// Grant is same-cycle combinational; read data returns registered one cycle later; losers simply wait for gnt.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int DEPTH     = 1024,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_write_data,
    output logic          ram_MemWrite,
    output logic          ram_MemRead,
    input  logic [DW-1:0] ram_read_data
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
    localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);

    arb_state_t    state, state_n;
    logic [CW-1:0] burst_cnt, cnt_n;
    logic          last;
    logic          sel_vld, sel;
    logic          own, req_own, req_oth;
    logic          gnt_any;
    logic          g_we, in_range;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;

    assign own     = (state == OWN1);
    assign req_own = own ? req1 : req0;
    assign req_oth = own ? req0 : req1;

    always_comb begin
        sel_vld = 1'b0;
        sel     = PORT_CPU;
        cnt_n   = burst_cnt;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    sel_vld = 1'b1;
                    sel     = ~last;
                end else if (req0 || req1) begin
                    sel_vld = 1'b1;
                    sel     = req1;
                end
                if (sel_vld) cnt_n = CW'(1);
            end
            default: begin
                // Owner keeps the RAM until its burst is spent while the other side waits.
                if (req_own && !(req_oth && burst_cnt == BURST_MAX)) begin
                    sel_vld = 1'b1;
                    sel     = own;
                    cnt_n   = (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + CW'(1);
                end else if (req_oth) begin
                    sel_vld = 1'b1;
                    sel     = ~own;
                    cnt_n   = CW'(1);
                end else begin
                    cnt_n   = '0;
                end
            end
        endcase
        state_n = !sel_vld ? IDLE : (sel ? OWN1 : OWN0);
    end

    // Reset gates the grant so no strobe reaches the RAM while reset is low.
    assign gnt_any = sel_vld & reset;
    assign gnt0    = gnt_any & ~sel;
    assign gnt1    = gnt_any & sel;

    assign g_we     = sel ? we1 : we0;
    assign g_addr   = sel ? addr1 : addr0;
    assign g_wdata  = sel ? wdata1 : wdata0;
    assign in_range = (g_addr < DEPTH_A);

    assign ram_MemWrite   = gnt_any & g_we & in_range;
    assign ram_MemRead    = gnt_any & ~g_we;
    assign ram_address    = gnt_any ? g_addr : '0;
    assign ram_write_data = gnt_any ? g_wdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last      <= PORT_LDR;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            burst_cnt <= cnt_n;
            if (gnt_any) last <= sel;
            rvalid0   <= gnt0 & ~we0;
            rvalid1   <= gnt1 & ~we1;
            err       <= gnt_any & ~in_range;
            if (gnt0 && !we0) rdata0 <= in_range ? ram_read_data : '0;
            if (gnt1 && !we1) rdata1 <= in_range ? ram_read_data : '0;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM and a history-based arbitration model.
module tb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 1024;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, err;
    logic [DW-1:0] rdata0, rdata1, ram_write_data, ram_read_data;
    logic [AW-1:0] ram_address;
    logic          ram_MemWrite, ram_MemRead;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_MemWrite(ram_MemWrite), .ram_MemRead(ram_MemRead),
        .ram_read_data(ram_read_data)
    );

    // Behavioural RAM next to the arbiter; out-of-range reads return junk so the arbiter must zero them.
    logic [DW-1:0] mem [0:DEPTH-1];
    assign ram_read_data = (ram_address < DEPTH) ? mem[ram_address[9:0]] : 32'hBAD0_0BAD;
    always @(posedge clk)
        if (ram_MemWrite && ram_address < DEPTH) mem[ram_address[9:0]] <= ram_write_data;

    // Reference model state
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    bit            m_prev_vld, m_prev_port, m_last;
    int            m_run;
    logic [DW-1:0] m_rd0, m_rd1;

    typedef struct {
        bit g0, g1, mw, mr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } gexp_t;
    typedef struct {
        bit rv0, rv1, er;
        logic [DW-1:0] rd0, rd1;
    } rexp_t;

    gexp_t exp_g[$];
    rexp_t exp_r[$];
    gexp_t ge;
    rexp_t re;
    bit    mon_en = 1'b0;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_vld = 1'b0;
        m_prev_port = 1'b0;
        m_last = 1'b1;
        m_run = 0;
        m_rd0 = '0;
        m_rd1 = '0;
    endtask

    // One cycle of stimulus: drive inputs, predict this cycle's grant and next cycle's response.
    task automatic drive_cycle(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               output bit g0, output bit g1);
        bit p, gv, w, inr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        gexp_t eg;
        rexp_t er;
        @(posedge clk);
        #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        gv = r0 | r1;
        if (!gv) p = 1'b0;
        else if (r0 ^ r1) p = r1;
        else if (!m_prev_vld) p = ~m_last;
        else if (m_run >= MAX_BURST) p = ~m_prev_port;
        else p = m_prev_port;
        g0 = gv & ~p;
        g1 = gv & p;
        w = p ? w1 : w0;
        a = p ? a1 : a0;
        d = p ? d1 : d0;
        inr = (a < DEPTH);
        eg.g0 = g0; eg.g1 = g1;
        eg.mw = gv & w & inr;
        eg.mr = gv & ~w;
        eg.addr = gv ? a : '0;
        eg.wd = gv ? d : '0;
        er.rv0 = g0 & ~w0;
        er.rv1 = g1 & ~w1;
        er.er = gv & ~inr;
        if (er.rv0) m_rd0 = inr ? ref_mem[a[9:0]] : '0;
        if (er.rv1) m_rd1 = inr ? ref_mem[a[9:0]] : '0;
        er.rd0 = m_rd0;
        er.rd1 = m_rd1;
        if (gv && w && inr) ref_mem[a[9:0]] = d;
        if (gv) begin
            m_run = (m_prev_vld && p == m_prev_port) ? m_run + 1 : 1;
            m_prev_port = p;
            m_last = p;
        end else begin
            m_run = 0;
        end
        m_prev_vld = gv;
        exp_g.push_back(eg);
        exp_r.push_back(er);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_g.size() == 0 || exp_r.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                ge = exp_g.pop_front();
                re = exp_r.pop_front();
                chk("gnt0", gnt0, ge.g0);
                chk("gnt1", gnt1, ge.g1);
                chk("ram_MemWrite", ram_MemWrite, ge.mw);
                chk("ram_MemRead", ram_MemRead, ge.mr);
                chk("ram_address", ram_address, ge.addr);
                chk("ram_write_data", ram_write_data, ge.wd);
                chk("rvalid0", rvalid0, re.rv0);
                chk("rvalid1", rvalid1, re.rv1);
                chk("rdata0", rdata0, re.rd0);
                chk("rdata1", rdata1, re.rd1);
                chk("err", err, re.er);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit g0, g1, p0, p1, w0r, w1r;
        logic [AW-1:0] a0r, a1r;
        logic [DW-1:0] d0r, d1r;
        rexp_t r_init;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();

        // Requests asserted during reset must not reach the RAM.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_memwrite", ram_MemWrite, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_err", err, 1'b0);
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        rst_n = 1'b1;
        r_init.rv0 = 0; r_init.rv1 = 0; r_init.er = 0; r_init.rd0 = '0; r_init.rd1 = '0;
        exp_r.push_back(r_init);
        #1 mon_en = 1'b1;

        // Write then read back on the CPU port
        drive_cycle(1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, g0, g1);
        drive_cycle(1, 0, 32'd5, 32'h0, 0, 0, 0, 0, g0, g1);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Both ports held reading: bursts of MAX_BURST alternate
        for (int i = 0; i < 12; i++) drive_cycle(1, 0, 32'd5, 0, 1, 0, 32'd6, 0, g0, g1);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Loader alone is never throttled
        for (int i = 0; i < 10; i++) drive_cycle(0, 0, 0, 0, 1, 0, 32'd5, 0, g0, g1);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Out-of-range write and read at exactly DEPTH
        drive_cycle(0, 0, 0, 0, 1, 1, 32'd1024, 32'h1, g0, g1);
        drive_cycle(0, 0, 0, 0, 1, 0, 32'd1024, 32'h0, g0, g1);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Loader write, CPU reads the same word the next cycle
        drive_cycle(0, 0, 0, 0, 1, 1, 32'd7, 32'h55, g0, g1);
        drive_cycle(1, 0, 32'd7, 0, 0, 0, 0, 0, g0, g1);

        // Random traffic obeying the hold-until-grant rule, with occasional withdrawals
        p0 = 0; p1 = 0;
        w0r = 0; w1r = 0; a0r = '0; a1r = '0; d0r = '0; d1r = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!p0 && $urandom_range(0, 9) < 6) begin
                p0 = 1; w0r = $urandom_range(0, 1);
                a0r = ($urandom_range(0, 19) == 0) ? 32'd1024 + $urandom_range(0, 3) : $urandom_range(0, 15);
                d0r = $urandom;
            end else if (p0 && $urandom_range(0, 9) == 0) p0 = 0;
            if (!p1 && $urandom_range(0, 9) < 6) begin
                p1 = 1; w1r = $urandom_range(0, 1);
                a1r = ($urandom_range(0, 19) == 0) ? 32'd1024 + $urandom_range(0, 3) : $urandom_range(0, 15);
                d1r = $urandom;
            end else if (p1 && $urandom_range(0, 9) == 0) p1 = 0;
            drive_cycle(p0, w0r, a0r, d0r, p1, w1r, a1r, d1r, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        @(negedge clk);
        #1 mon_en = 1'b0;
        exp_g.delete();
        exp_r.delete();

        // Reset asserted in the middle of a granted write
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'h1234_5678;
        #1 chk("pre_rst_memwrite", ram_MemWrite, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_memwrite", ram_MemWrite, 1'b0);
        chk("mid_rst_gnt0", gnt0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt0", gnt0, 1'b0);
        chk("post_rst_gnt1", gnt1, 1'b0);
        chk("post_rst_rvalid0", rvalid0, 1'b0);
        chk("post_rst_rvalid1", rvalid1, 1'b0);
        chk("post_rst_rdata0", rdata0, 32'h0);
        chk("post_rst_rdata1", rdata1, 32'h0);
        chk("post_rst_err", err, 1'b0);
        chk("post_rst_memread", ram_MemRead, 1'b0);
        chk("post_rst_mem9", mem[9], ref_mem[9]);

        // After reset the first tie goes to the CPU again
        @(posedge clk);
        #1;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'd1; addr1 = 32'd2;
        #1;
        chk("tie_gnt0", gnt0, 1'b1);
        chk("tie_gnt1", gnt1, 1'b0);
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
